truth_table_scanner: RTL and testbench

Sequential stimulus-and-check stage that sits directly upstream of the three-input mux function block (s = f(a,b,c), built from three 2:1 muxes) and also consumes its output. On a start pulse it walks the input vector {a,b,c} through all 8 combinations. It holds each vector for a programmable settle time and samples the function output into an 8-bit truth-table word. It then compares that word against an expected table and reports the result with a one-cycle done pulse. This replaces manual testbench stepping with an in-design self-check.

---
 rtl/truth_table_scanner.sv | 152 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Drives the three select/data inputs {a,b,c} of a combinational function
// block through all eight combinations. Each vector is held for a
// programmable settle time. The returned function output is captured into
// an 8-bit truth table, which is compared against a golden table. A scan is
// started by a pulse on start. Completion is signalled by a one-cycle done
// pulse. The results then hold until the next accepted start.
//
// Parameters
//   SETTLE    cycles each vector spends in DRIVE before its sample cycle (1..15)
//   EXPECTED  golden truth table, bit i = expected s for {a,b,c} = i
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset
//   start           in   scan request, honoured only in IDLE
//   a_out/b_out/c_out out stimulus vector, {a,b,c} = idx
//   s_in            in   function output from the block under test
//   busy            out  high while driving/sampling vectors
//   done            out  one-cycle completion pulse
//   table_out       out  captured truth table
//   mismatch_count  out  number of table bits differing from EXPECTED
//   first_fail      out  lowest mismatching index (0 if none)
//   match           out  1 when the last completed scan had no mismatches

module truth_table_scanner #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [7:0]  EXPECTED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       s_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] mismatch_count,
  output logic [2:0] first_fail,
  output logic       match
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The settle counter counts down to zero, so DRIVE lasts exactly SETTLE cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [3:0] settle_q;
  logic [7:0] table_q;
  logic [3:0] mm_count_q;
  logic [2:0] first_fail_q;
  logic       ff_seen_q;
  logic       match_q;

  // Next values used by the SAMPLE state.
  logic       bit_miss_d;
  logic [3:0] mm_count_d;
  logic [7:0] table_d;

  always_comb begin
    bit_miss_d       = (s_in != EXPECTED[idx_q]);
    mm_count_d       = bit_miss_d ? (mm_count_q + 4'd1) : mm_count_q;
    table_d          = table_q;
    table_d[idx_q]   = s_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      settle_q     <= 4'd0;
      table_q      <= 8'h00;
      mm_count_q   <= 4'd0;
      first_fail_q <= 3'd0;
      ff_seen_q    <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= DRIVE;
            idx_q        <= 3'd0;
            settle_q     <= SETTLE_LOAD;
            table_q      <= 8'h00;
            mm_count_q   <= 4'd0;
            first_fail_q <= 3'd0;
            ff_seen_q    <= 1'b0;
            match_q      <= 1'b0;
          end
        end

        DRIVE: begin
          if (settle_q == 4'd0) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end

        SAMPLE: begin
          table_q    <= table_d;
          mm_count_q <= mm_count_d;
          if (bit_miss_d && !ff_seen_q) begin
            first_fail_q <= idx_q;
            ff_seen_q    <= 1'b1;
          end
          if (idx_q == 3'd7) begin
            // Verdict is registered on DONE entry so it is valid alongside done.
            state_q <= DONE;
            idx_q   <= 3'd0;
            match_q <= (mm_count_d == 4'd0);
          end else begin
            state_q  <= DRIVE;
            idx_q    <= idx_q + 3'd1;
            settle_q <= SETTLE_LOAD;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Every output comes straight from a register or from a decode of the state
  // register alone, so nothing here can glitch on start.
  assign a_out          = idx_q[2];
  assign b_out          = idx_q[1];
  assign c_out          = idx_q[0];
  assign busy           = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done           = (state_q == DONE);
  assign table_out      = table_q;
  assign mismatch_count = mm_count_q;
  assign first_fail     = first_fail_q;
  assign match          = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  typedef struct {
    logic [7:0] tbl;
    logic [3:0] mm;
    logic [2:0] ff;
    logic       m;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with SETTLE=1 (function output selectable by mode).
  logic       rst, start, s_in;
  logic       a_o, b_o, c_o, busy, done, match;
  logic [7:0] table_out;
  logic [3:0] mismatch_count;
  logic [2:0] first_fail;

  // Instance with SETTLE=3 (always driven by the real function).
  logic       rst3, start3, s_in3;
  logic       a3, b3, c3, busy3, done3, match3;
  logic [7:0] table3;
  logic [3:0] mm3;
  logic [2:0] ff3;

  int mode;  // 0 golden mux, 1 stuck 0, 2 stuck 1, 3 inverted (a ^ c)

  truth_table_scanner #(.SETTLE(1), .EXPECTED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_o), .b_out(b_o), .c_out(c_o), .s_in(s_in),
    .busy(busy), .done(done), .table_out(table_out),
    .mismatch_count(mismatch_count), .first_fail(first_fail), .match(match)
  );

  truth_table_scanner #(.SETTLE(3), .EXPECTED(8'hA5)) dut3 (
    .clk(clk), .rst(rst3), .start(start3),
    .a_out(a3), .b_out(b3), .c_out(c3), .s_in(s_in3),
    .busy(busy3), .done(done3), .table_out(table3),
    .mismatch_count(mm3), .first_fail(ff3), .match(match3)
  );

  // Function block under test: three 2:1 muxes giving s = a ? c : ~c.
  function automatic logic mux_fn(input logic a, input logic c);
    logic lo, hi;
    lo = c ? 1'b0 : 1'b1;
    hi = c ? 1'b1 : 1'b0;
    return a ? hi : lo;
  endfunction

  always_comb begin
    s_in = 1'b0;
    case (mode)
      0:       s_in = mux_fn(a_o, c_o);
      1:       s_in = 1'b0;
      2:       s_in = 1'b1;
      default: s_in = a_o ^ c_o;
    endcase
  end
  assign s_in3 = mux_fn(a3, c3);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  exp_t q[$];
  exp_t q3[$];
  int   pushes = 0, dones = 0, dones3 = 0;
  exp_t mon_e, mon_e3;

  // Scoreboards: compare results whenever a done pulse is observed.
  always @(negedge clk) begin
    if (done) begin
      dones++;
      $display("scan done (SETTLE=1): table=%h mismatches=%0d first_fail=%0d match=%0d",
               table_out, mismatch_count, first_fail, match);
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("table_out", 32'(table_out), 32'(mon_e.tbl));
        check("mismatch_count", 32'(mismatch_count), 32'(mon_e.mm));
        check("first_fail", 32'(first_fail), 32'(mon_e.ff));
        check("match", 32'(match), 32'(mon_e.m));
      end
    end
  end

  always @(negedge clk) begin
    if (done3) begin
      dones3++;
      $display("scan done (SETTLE=3): table=%h mismatches=%0d first_fail=%0d match=%0d",
               table3, mm3, ff3, match3);
      if (q3.size() == 0) begin
        check("unexpected_done3", 32'd1, 32'd0);
      end else begin
        mon_e3 = q3.pop_front();
        check("table_out3", 32'(table3), 32'(mon_e3.tbl));
        check("mismatch_count3", 32'(mm3), 32'(mon_e3.mm));
        check("first_fail3", 32'(ff3), 32'(mon_e3.ff));
        check("match3", 32'(match3), 32'(mon_e3.m));
      end
    end
  end

  function automatic logic [31:0] outs1();
    return 32'({a_o, b_o, c_o, busy, done, table_out, mismatch_count, first_fail, match});
  endfunction

  function automatic logic [31:0] outs3();
    return 32'({a3, b3, c3, busy3, done3, table3, mm3, ff3, match3});
  endfunction

  // One scan on the SETTLE=1 instance; optionally pokes start during busy and DONE.
  task automatic run_scan(input string name, input int md, input exp_t e, input bit abuse);
    int  cyc, busy_n;
    bit  seen;
    @(negedge clk);
    mode = md;
    q.push_back(e);
    pushes++;
    start = 1'b1;
    @(posedge clk);  // E0
    #1 start = 1'b0;
    cyc = 0; busy_n = 0; seen = 0;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen  = 1;
        start = abuse;  // lands on the DONE-state edge, must be ignored
      end else begin
        if (busy) busy_n++;
        start = abuse && (cyc % 2 == 1);
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_done_cycle"}, 32'(cyc), 32'd17);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd16);
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse_width"}, 32'(done), 32'd0);
    check({name, "_idle_after_done"}, 32'(busy), 32'd0);
    if (abuse) begin
      repeat (3) @(negedge clk);
      check({name, "_no_rescan"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_done1(input string name);
    int cyc;
    cyc = 0;
    while (cyc < 200 && !done) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int   cyc, busy_n, d_before;
    bit   seen;
    rst = 1'b1; rst3 = 1'b1; start = 1'b0; start3 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs1(), 32'd0);
    check("reset_outputs3", outs3(), 32'd0);
    rst = 1'b0; rst3 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while idle with start high; no scan may follow release.
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_idle_start_outputs", outs1(), 32'd0);
    start = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);
    check("no_scan_after_reset", 32'(busy), 32'd0);
    check("no_done_after_reset", 32'(dones), 32'd0);

    run_scan("golden",   0, exp_t'{8'hA5, 4'd0, 3'd0, 1'b1}, 1'b0);
    run_scan("stuck0",   1, exp_t'{8'h00, 4'd4, 3'd0, 1'b0}, 1'b0);
    run_scan("stuck1",   2, exp_t'{8'hFF, 4'd4, 3'd1, 1'b0}, 1'b0);
    run_scan("inverted", 3, exp_t'{8'h5A, 4'd8, 3'd0, 1'b0}, 1'b0);
    run_scan("abuse",    0, exp_t'{8'hA5, 4'd0, 3'd0, 1'b1}, 1'b1);

    // start held high: back-to-back scans, each cleared when accepted.
    @(negedge clk);
    mode = 2;
    q.push_back(exp_t'{8'hFF, 4'd4, 3'd1, 1'b0});
    pushes++;
    start = 1'b1;
    wait_done1("held_first");
    @(negedge clk);
    check("held_gap_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_cleared_table", 32'(table_out), 32'd0);
    check("held_cleared_mm", 32'(mismatch_count), 32'd0);
    check("held_cleared_ff", 32'(first_fail), 32'd0);
    check("held_cleared_match", 32'(match), 32'd0);
    mode = 0;
    q.push_back(exp_t'{8'hA5, 4'd0, 3'd0, 1'b1});
    pushes++;
    start = 1'b0;
    wait_done1("held_second");
    repeat (3) @(negedge clk);

    // Reset the SETTLE=3 instance mid-scan at idx=3.
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    cyc = 0;
    while (cyc < 200 && {a3, b3, c3} != 3'd3) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_idx3", 32'({a3, b3, c3}), 32'd3);
    d_before = dones3;
    rst3 = 1'b1;
    #1;
    check("abort_outputs_immediate", outs3(), 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(dones3), 32'(d_before));
    check("abort_stays_idle", 32'(busy3), 32'd0);

    // Full SETTLE=3 scan: done after E32.
    q3.push_back(exp_t'{8'hA5, 4'd0, 3'd0, 1'b1});
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    cyc = 0; busy_n = 0; seen = 0;
    while (cyc < 300 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done3) seen = 1;
      else if (busy3) busy_n++;
    end
    check("settle3_done_seen", 32'(seen), 32'd1);
    check("settle3_done_cycle", 32'(cyc), 32'd33);
    check("settle3_busy_cycles", 32'(busy_n), 32'd32);
    repeat (2) @(negedge clk);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    check("scoreboard3_empty", 32'(q3.size()), 32'd0);
    check("done_count", 32'(dones), 32'(pushes));
    check("done3_count", 32'(dones3), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
